// File: rtl/src_stim.sv
// src_stim: framed AXI4-Stream stimulus source (counter/impulse/LFSR/const).
// Define SRC_GAP_EN to build the inter-frame GAP state driven by gap_len.
module src_stim #(
  parameter int          WIDTH   = 16,
  parameter int          MAX_CNT = 2048,
  parameter int          NCHAN   = 1,
  parameter string       ORDER   = "natural",
  parameter logic [31:0] SEED    = 32'h1,
  localparam int         IW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1,
  localparam int         UW      = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] amp,
  input  logic [IW-1:0]    imp_pos,
  input  logic [15:0]      gap_len,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [UW-1:0]    m_axis_tuser,
  output logic [31:0]      frame_cnt
);

  localparam logic [31:0] SEED_I =
    (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam bit BITREV = (ORDER == "bitrev");
  localparam logic [IW-1:0] IDX_MAX = IW'(MAX_CNT - 1);
  localparam logic [UW-1:0] CH_MAX  = UW'(NCHAN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN
`ifdef SRC_GAP_EN
    ,
    GAP
`endif
  } state_t;

  state_t           state, state_d;
  logic [IW-1:0]    idx, idx_d;
  logic [UW-1:0]    ch, ch_d;
  logic [31:0]      lfsr, lfsr_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] amp_q, amp_d;
  logic [IW-1:0]    imp_q, imp_d;
  logic             vld_d;
  logic             load;
  logic             latch;
  logic             frm_inc;
  logic             hs;
  logic             last;
  logic             last_d;
  logic [WIDTH-1:0] data_d;

`ifdef SRC_GAP_EN
  logic [15:0]      gap_cnt, gap_d;
`else
  logic             unused_gap;
  assign unused_gap = ^gap_len;
`endif

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  function automatic logic [IW-1:0] order_idx(
    input logic [IW-1:0] i
  );
    logic [IW-1:0] r;
    r = i;
    if (BITREV)
      for (int b = 0; b < IW; b++)
        r[b] = i[IW-1-b];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] beat_data(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] a,
    input logic [IW-1:0]    ip,
    input logic [IW-1:0]    i,
    input logic [UW-1:0]    c,
    input logic [31:0]      s
  );
    logic [IW-1:0]    io;
    logic [WIDTH-1:0] r;
    io = order_idx(i);
    case (m)
      2'd0: r = WIDTH'(io)
              + WIDTH'(c) * WIDTH'(MAX_CNT);
      2'd1: r = (io == ip) ? a : '0;
      2'd2: r = WIDTH'(s);
      default: r = a;
    endcase
    return r;
  endfunction

  assign hs   = m_axis_tvalid & m_axis_tready;
  assign last = (idx == IDX_MAX) && (ch == CH_MAX);

  always_comb begin
    state_d = state;
    idx_d   = idx;
    ch_d    = ch;
    lfsr_d  = lfsr;
    mode_d  = mode_q;
    amp_d   = amp_q;
    imp_d   = imp_q;
    vld_d   = m_axis_tvalid;
    load    = 1'b0;
    latch   = 1'b0;
    frm_inc = 1'b0;
`ifdef SRC_GAP_EN
    gap_d   = gap_cnt;
`endif
    if (hs)
      lfsr_d = lfsr_step(lfsr);
    unique case (state)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          latch   = 1'b1;
        end
      end
      RUN: begin
        if (!m_axis_tvalid) begin
          // first beat after leaving IDLE
          load  = 1'b1;
          vld_d = 1'b1;
        end else if (hs) begin
          if (last) begin
            frm_inc = 1'b1;
            idx_d   = '0;
            ch_d    = '0;
            if (!en) begin
              state_d = IDLE;
              vld_d   = 1'b0;
`ifdef SRC_GAP_EN
            end else if (gap_len != 16'd0) begin
              state_d = GAP;
              vld_d   = 1'b0;
              gap_d   = gap_len;
`endif
            end else begin
              latch = 1'b1;
              load  = 1'b1;
            end
          end else begin
            load = 1'b1;
            if (ch == CH_MAX) begin
              ch_d  = '0;
              idx_d = idx + IW'(1);
            end else begin
              ch_d  = ch + UW'(1);
            end
          end
        end
      end
`ifdef SRC_GAP_EN
      GAP: begin
        if (gap_cnt == 16'd1) begin
          if (en) begin
            state_d = RUN;
            latch   = 1'b1;
            load    = 1'b1;
            vld_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_cnt - 16'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (latch) begin
      mode_d = mode;
      amp_d  = amp;
      imp_d  = imp_pos;
    end
  end

  assign last_d = (idx_d == IDX_MAX)
                && (ch_d == CH_MAX);
  assign data_d = beat_data(mode_d, amp_d,
                            imp_d, idx_d,
                            ch_d, lfsr_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      ch            <= '0;
      lfsr          <= SEED_I;
      mode_q        <= '0;
      amp_q         <= '0;
      imp_q         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      frame_cnt     <= '0;
`ifdef SRC_GAP_EN
      gap_cnt       <= '0;
`endif
    end else begin
      state         <= state_d;
      idx           <= idx_d;
      ch            <= ch_d;
      lfsr          <= lfsr_d;
      mode_q        <= mode_d;
      amp_q         <= amp_d;
      imp_q         <= imp_d;
      m_axis_tvalid <= vld_d;
`ifdef SRC_GAP_EN
      gap_cnt       <= gap_d;
`endif
      if (load) begin
        m_axis_tdata <= data_d;
        m_axis_tlast <= last_d;
        m_axis_tuser <= ch_d;
      end else if (!vld_d) begin
        m_axis_tlast <= 1'b0;
      end
      if (frm_inc)
        frame_cnt <= frame_cnt + 32'd1;
    end
  end

endmodule

// File: doc/src_stim.md
# src_stim

Parametrised AXI4-Stream stimulus source that generates framed test data for the OSPFB datapath. It supersedes the single-mode natural-order counter source. It adds time-interleaved channels, bit-reversed ordering, four run-time data modes, backpressure-safe output and frame accounting. It sits at the head of simulation and loopback hardware-test chains, driving the filter's `s_axis`.

## Interface
- `WIDTH`, 16: tdata width in bits.
- `MAX_CNT`, 2048: samples per frame per channel. Must be a power of two when `ORDER="bitrev"`.
- `NCHAN`, 1: number of time-interleaved channels, 1..256.
- `ORDER`, "natural": sample index order, either "natural" or "bitrev" (reversal over log2(MAX_CNT) bits).
- `SEED`, 32'h1: LFSR reset seed. A value of 0 is replaced by 1.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run request.
- `mode` in 2: data mode. 0 = counter, 1 = impulse, 2 = LFSR, 3 = constant.
- `amp` in WIDTH: impulse/constant amplitude.
- `imp_pos` in clog2(MAX_CNT): impulse sample index.
- `gap_len` in 16: idle cycles between frames. Used only with `SRC_GAP_EN`.
- `m_axis_tdata` out WIDTH: sample.
- `m_axis_tvalid` out 1: sample valid.
- `m_axis_tready` in 1: sink ready.
- `m_axis_tlast` out 1: last beat of frame.
- `m_axis_tuser` out max(1,clog2(NCHAN)): channel index of the current beat.
- `frame_cnt` out 32: completed frames, wraps modulo 2^32.

## Operation
- Counters:
  - `ch` runs 0..NCHAN-1 and advances on every handshake (tvalid & tready).
  - `idx` runs 0..MAX_CNT-1 and advances when `ch` wraps.
  - `idx_o` is `idx` for natural order, or `idx` with its log2(MAX_CNT) bits reversed for bitrev.
- Data per beat:
  - Counter: (idx_o + ch·MAX_CNT) mod 2^WIDTH.
  - Impulse: amp when idx_o == imp_pos, else 0. Applies to all channels.
  - LFSR: low WIDTH bits of a 32-bit Galois LFSR (polynomial 0x80200003). The LFSR steps once per handshake. If WIDTH > 32, the value is zero-extended.
  - Constant: amp.
- tlast is 1 exactly on the beat with idx == MAX_CNT-1 and ch == NCHAN-1. `frame_cnt` increments on that handshake.
- `mode`, `amp` and `imp_pos` are latched at frame start, when leaving IDLE or GAP or on wrapping to idx 0. Changing them mid-frame has no effect until the next frame.
- FSM states:
  - IDLE: tvalid = 0, idx = ch = 0. Moves to RUN when `en` is sampled high.
  - RUN: presents beats. On the tlast handshake:
    - `en` low → IDLE.
    - `SRC_GAP_EN` defined and gap_len ≠ 0 → GAP.
    - Otherwise → RUN at idx 0, with no bubble.
  - GAP: tvalid = 0 for gap_len cycles, then moves to RUN, or to IDLE if `en` is low at that point.
  - Deasserting `en` mid-frame does not truncate the frame; the current frame completes first.
- AXIS rules:
  - Once tvalid is high, tdata, tlast and tuser hold stable until the handshake.
  - tvalid never drops without a handshake.
  - tready has no combinational path to any output.
- LFSR state persists across frames and across IDLE. Only `rst` reloads SEED.

## Timing
- Reset values: tvalid 0, tdata 0, tlast 0, tuser 0, frame_cnt 0, state IDLE, idx 0, ch 0, LFSR = SEED.
- `rst` asserted mid-frame returns all state to reset values on the next edge, regardless of tready. The partial frame is abandoned.
- All outputs are registered.
- `en` sampled high in IDLE at edge n gives tvalid = 1 with idx 0, ch 0 after edge n+1.
- With continuous tready and no gap, throughput is one beat per cycle, including across frame boundaries.
- If tready is low at a tlast beat, the FSM stays in RUN holding that beat.
- GAP of length L gives exactly L tvalid-low cycles between the tlast handshake and the next first beat.
- `frame_cnt` updates on the edge that completes the tlast handshake.

## Configuration
- `SRC_GAP_EN` defined: GAP state and `gap_len` are active, modelling producer/consumer rate mismatch.
- `SRC_GAP_EN` undefined: the GAP state is not built and `gap_len` is ignored; frames are back-to-back.

## Test plan
- Counter, natural order:
  - Stimulus: WIDTH=16, MAX_CNT=8, NCHAN=1, tready=1, en=1.
  - Required: tdata 0..7 repeating; tlast on 7; frame_cnt = 3 after 24 beats.
- Counter, bitrev, two channels:
  - Stimulus: ORDER="bitrev", MAX_CNT=8, NCHAN=2.
  - Required: beats (tdata,tuser) = (0,0),(8,1),(4,0),(12,1),(2,0),(10,1),...; tlast only on the 16th beat.
- Backpressure:
  - Stimulus: random tready (50 %), counter mode.
  - Required: no data change while tvalid & !tready; sequence identical to the tready=1 run.
- Impulse with mid-frame mode change:
  - Stimulus: mode=1, amp=0x7FFF, imp_pos=3, MAX_CNT=8; switch to mode=3 at beat 5.
  - Required: frame 0 is 0,0,0,0x7FFF,0,0,0,0; frame 1 is all 0x7FFF.
- LFSR with en drop and gap:
  - Stimulus: SEED=1, mode=2, MAX_CNT=4; en low at beat 2; `SRC_GAP_EN` defined with gap_len=3 on rerun.
  - Required: frame completes 4 beats then tvalid=0; LFSR continues without reseeding; exactly 3 idle cycles between frames.
- Reset mid-frame:
  - Stimulus: rst=1 at beat 5 with tready=0.
  - Required: tvalid, tlast, tdata and frame_cnt are 0 next cycle; restart begins at idx 0 with LFSR = SEED.
